// File: rtl/data_mem_unit.sv
// Data-side memory unit for a single-cycle CPU: word RAM with combinational reads plus
// an MMIO window holding a TX byte FIFO, a free-running cycle counter and sticky errors.
module data_mem_unit #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataAddress,
  input  logic [31:0] writeMemData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  memMode,
  output logic [31:0] readMemData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        memError
);
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  localparam logic [2:0] MODE_WORD   = 3'd0;
  localparam logic [2:0] MODE_HALF_S = 3'd1;
  localparam logic [2:0] MODE_HALF_U = 3'd2;
  localparam logic [2:0] MODE_BYTE_S = 3'd3;
  localparam logic [2:0] MODE_BYTE_U = 3'd4;

  localparam logic [3:0] REG_TX    = 4'd0;
  localparam logic [3:0] REG_CNT   = 4'd1;
  localparam logic [3:0] REG_STAT  = 4'd2;
  localparam logic [3:0] REG_EADDR = 4'd3;

  // ---------------- access decode ----------------
  logic isWord, isHalf, isByte, isSigned, modeValid;
  logic isRam, isMmio, misaligned, accessActive, accessErr;
  logic mmioWr, mmioRd;
  logic [3:0] mmioReg;

  assign isWord    = (memMode == MODE_WORD);
  assign isHalf    = (memMode == MODE_HALF_S) || (memMode == MODE_HALF_U);
  assign isByte    = (memMode == MODE_BYTE_S) || (memMode == MODE_BYTE_U);
  assign isSigned  = (memMode == MODE_HALF_S) || (memMode == MODE_BYTE_S);
  assign modeValid = isWord | isHalf | isByte;

  // The MMIO window is 64 bytes, so matching the upper 26 bits selects it.
  assign isRam  = ({1'b0, dataAddress} < RAM_BYTES);
  assign isMmio = (dataAddress[31:6] == MMIO_BASE[31:6]);
  assign misaligned = (isWord && (dataAddress[1:0] != 2'b00)) || (isHalf && dataAddress[0]);

  assign accessActive = memRead | memWrite;
  assign accessErr = accessActive &&
                     (!modeValid || !(isRam || isMmio) || misaligned || (isMmio && !isWord));

  assign mmioReg = dataAddress[5:2];
  assign mmioWr  = memWrite && isMmio && !accessErr;
  assign mmioRd  = memRead && isMmio && !accessErr;

  // ---------------- word RAM ----------------
  logic [31:0]       ramMem [RAM_WORDS];
  logic [RAM_AW-1:0] wordIdx;
  logic [31:0]       ramWord, laneData, mergedWord, ramLoad;
  logic [3:0]        byteEn;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic              ramWe;

  assign wordIdx = dataAddress[RAM_AW+1:2];
  assign ramWord = ramMem[wordIdx];
  assign ramWe   = memWrite && isRam && !accessErr;

  // Store data is replicated into every lane; byteEn picks the lanes that change.
  always_comb begin
    byteEn   = 4'b0000;
    laneData = writeMemData;
    if (isWord) begin
      byteEn = 4'b1111;
    end else if (isHalf) begin
      laneData = {2{writeMemData[15:0]}};
      byteEn   = dataAddress[1] ? 4'b1100 : 4'b0011;
    end else if (isByte) begin
      laneData = {4{writeMemData[7:0]}};
      byteEn   = 4'b0001 << dataAddress[1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign mergedWord[gi*8 +: 8] = byteEn[gi] ? laneData[gi*8 +: 8] : ramWord[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ramWe) begin
      ramMem[wordIdx] <= mergedWord;
    end
  end

  assign loadByte = ramWord[{dataAddress[1:0], 3'b000} +: 8];
  assign loadHalf = dataAddress[1] ? ramWord[31:16] : ramWord[15:0];

  always_comb begin
    ramLoad = ramWord;
    if (isHalf) begin
      ramLoad = {{16{isSigned & loadHalf[15]}}, loadHalf};
    end else if (isByte) begin
      ramLoad = {{24{isSigned & loadByte[7]}}, loadByte};
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifoMem [TX_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic             txFull, txEmpty, pushReq, pushDo, popDo;

  assign txFull  = (fifoCount == CNT_W'(TX_DEPTH));
  assign txEmpty = (fifoCount == '0);
  assign pushReq = mmioWr && (mmioReg == REG_TX);
  assign pushDo  = pushReq && !txFull;
  assign popDo   = !txEmpty && txReady;

  always_ff @(posedge clk) begin
    if (pushDo) begin
      fifoMem[wrPtr] <= writeMemData[7:0];
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      wrPtr     <= wrPtr + PTR_W'(pushDo);
      rdPtr     <= rdPtr + PTR_W'(popDo);
      fifoCount <= fifoCount + CNT_W'(pushDo) - CNT_W'(popDo);
    end
  end

  assign txValid = !txEmpty;
  assign txData  = txEmpty ? 8'h00 : fifoMem[rdPtr];

  // ---------------- counter and sticky errors ----------------
  logic [31:0] cycleCount, errAddr;
  logic        errReg, ovfReg, statWr, errClr, ovfClr, ovfSet;

  assign statWr = mmioWr && (mmioReg == REG_STAT);
  assign errClr = statWr && writeMemData[1];
  assign ovfClr = statWr && writeMemData[2];
  assign ovfSet = pushReq && txFull;

  // Clear beats a same-cycle set; errAddr only latches the first fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= '0;
      errReg     <= 1'b0;
      ovfReg     <= 1'b0;
      errAddr    <= '0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      errReg     <= (errReg | accessErr) & ~errClr;
      ovfReg     <= (ovfReg | ovfSet) & ~ovfClr;
      if (accessErr && !errReg) begin
        errAddr <= dataAddress;
      end
    end
  end

  assign memError = errReg | ovfReg;

  // ---------------- load mux ----------------
  always_comb begin
    readMemData = 32'h0;
    if (memRead && !accessErr) begin
      if (isRam) begin
        readMemData = ramLoad;
      end else if (mmioRd) begin
        case (mmioReg)
          REG_TX:    readMemData = {30'b0, txFull, txEmpty};
          REG_CNT:   readMemData = cycleCount;
          REG_STAT:  readMemData = {29'b0, ovfReg, errReg, 1'b0};
          REG_EADDR: readMemData = errAddr;
          default:   readMemData = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: byte-level behavioural model checked every cycle on the falling
// edge, plus directed scenarios with hand-computed expectations.
module tb_data_mem_unit;
  localparam logic [31:0] MMIO = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataAddress, writeMemData, readMemData;
  logic        memRead, memWrite, txValid, txReady, memError;
  logic [2:0]  memMode;
  logic [7:0]  txData;

  always #5 clk = ~clk;

  data_mem_unit #(.RAM_WORDS(1024), .TX_DEPTH(4), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .reset(reset), .dataAddress(dataAddress), .writeMemData(writeMemData),
    .memRead(memRead), .memWrite(memWrite), .memMode(memMode), .readMemData(readMemData),
    .txData(txData), .txValid(txValid), .txReady(txReady), .memError(memError)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mRam [0:4095];
  logic [7:0]  mQ[$];
  bit          mErr, mOvf;
  logic [31:0] mErrAddr, mCnt;

  function automatic int accSize(input logic [2:0] m);
    case (m)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit inMmio(input logic [31:0] a);
    return (a >= MMIO) && (a <= MMIO + 32'd63);
  endfunction

  function automatic bit isFault(input logic [31:0] a, input logic [2:0] m, input bit active);
    int sz;
    sz = accSize(m);
    if (!active) return 1'b0;
    if (sz == 0) return 1'b1;
    if (!(a < 32'd4096) && !inMmio(a)) return 1'b1;
    if (a % sz != 0) return 1'b1;
    if (inMmio(a) && sz != 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] expRead();
    logic [31:0] v;
    logic [31:0] off;
    int sz;
    if (!memRead || isFault(dataAddress, memMode, 1'b1)) return 32'h0;
    sz = accSize(memMode);
    if (dataAddress < 32'd4096) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(mRam[dataAddress + i]) << (8 * i));
      if (memMode == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      if (memMode == 3'd3 && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    off = dataAddress - MMIO;
    case (off)
      32'd0:   return (mQ.size() == 4 ? 32'd2 : 32'd0) + (mQ.size() == 0 ? 32'd1 : 32'd0);
      32'd4:   return mCnt;
      32'd8:   return (mOvf ? 32'd4 : 32'd0) + (mErr ? 32'd2 : 32'd0);
      32'd12:  return mErrAddr;
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelStep();
    bit f, mm, pushReq, w1c, full, popNow;
    logic [31:0] off;
    f       = isFault(dataAddress, memMode, memRead | memWrite);
    mm      = inMmio(dataAddress);
    off     = dataAddress - MMIO;
    pushReq = memWrite && !f && mm && off == 0;
    w1c     = memWrite && !f && mm && off == 8;
    full    = (mQ.size() == 4);
    popNow  = (mQ.size() > 0) && txReady;
    if (memWrite && !f && dataAddress < 32'd4096)
      for (int i = 0; i < accSize(memMode); i++) mRam[dataAddress + i] = 8'(writeMemData >> (8 * i));
    if (f && !mErr) mErrAddr = dataAddress;
    mErr = (mErr || f) && !(w1c && writeMemData[1]);
    mOvf = (mOvf || (pushReq && full)) && !(w1c && writeMemData[2]);
    if (popNow) void'(mQ.pop_front());
    if (pushReq && !full) mQ.push_back(writeMemData[7:0]);
    mCnt = mCnt + 32'd1;
  endtask

  // Compare process: outputs reflect the state after the last edge plus current inputs.
  always @(negedge clk) begin
    if (reset) begin
      mQ.delete();
      mErr = 1'b0; mOvf = 1'b0; mErrAddr = 32'h0; mCnt = 32'h0;
    end else begin
      chk("readMemData", readMemData, expRead());
      chk("txValid", 32'(txValid), 32'(mQ.size() > 0));
      chk("txData", 32'(txData), (mQ.size() > 0) ? 32'(mQ[0]) : 32'h0);
      chk("memError", 32'(memError), 32'(mErr | mOvf));
      modelStep();
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                       input logic [2:0] m, input bit rdy);
    @(posedge clk);
    #1;
    dataAddress = a; writeMemData = wd; memRead = rd; memWrite = wr; memMode = m; txReady = rdy;
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, rdy);
  endtask

  logic [31:0] c1, c2, a;
  logic [7:0]  str [5];
  logic [2:0]  m;

  initial begin
    reset = 1'b1;
    dataAddress = 0; writeMemData = 0; memRead = 0; memWrite = 0; memMode = 0; txReady = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_txValid", 32'(txValid), 32'h0);
    chk("rst_txData", 32'(txData), 32'h0);
    chk("rst_memError", 32'(memError), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    drive(MMIO + 4, 0, 1, 0, 3'd0, 0);
    chk("cnt_first", readMemData, 32'd1);

    for (int i = 0; i < 64; i++) drive(32'(i * 4), $urandom, 0, 1, 3'd0, 0);
    drive(32'hFFC, $urandom, 0, 1, 3'd0, 0);

    // byte loads from a word store
    drive(32'h10, 32'hDEADBEEF, 0, 1, 3'd0, 0);
    drive(32'h13, 0, 1, 0, 3'd3, 0);
    chk("lb_signed", readMemData, 32'hFFFFFFDE);
    drive(32'h10, 0, 1, 0, 3'd4, 0);
    chk("lbu", readMemData, 32'h000000EF);

    // half store into upper lane
    drive(32'h20, 32'hAAAAAAAA, 0, 1, 3'd0, 0);
    drive(32'h22, 32'h00001234, 0, 1, 3'd1, 0);
    drive(32'h20, 0, 1, 0, 3'd0, 0);
    chk("half_merge", readMemData, 32'h1234AAAA);

    // misaligned load, error capture and W1C
    drive(32'h06, 0, 1, 0, 3'd0, 0);
    chk("misalign_rd", readMemData, 32'h0);
    chk("err_not_yet", 32'(memError), 32'h0);
    idle(0);
    chk("err_set", 32'(memError), 32'h1);
    drive(MMIO + 12, 0, 1, 0, 3'd0, 0);
    chk("err_addr", readMemData, 32'h6);
    drive(MMIO + 8, 0, 1, 0, 3'd0, 0);
    chk("stat_err", readMemData, 32'h2);
    drive(MMIO + 8, 32'h2, 0, 1, 3'd0, 0);
    drive(MMIO + 8, 0, 1, 0, 3'd0, 0);
    chk("stat_clr", readMemData, 32'h0);
    chk("err_clr", 32'(memError), 32'h0);

    // FIFO overflow and drain
    str[0] = "A"; str[1] = "B"; str[2] = "C"; str[3] = "D"; str[4] = "E";
    for (int i = 0; i < 5; i++) drive(MMIO, 32'(str[i]), 0, 1, 3'd0, 0);
    drive(MMIO, 0, 1, 0, 3'd0, 0);
    chk("fifo_full", readMemData, 32'h2);
    drive(MMIO + 8, 0, 1, 0, 3'd0, 0);
    chk("stat_ovf", readMemData, 32'h4);
    chk("ovf_err", 32'(memError), 32'h1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("drain_valid", 32'(txValid), 32'h1);
      chk("drain_data", 32'(txData), 32'(str[i]));
    end
    idle(1);
    chk("drain_empty", 32'(txValid), 32'h0);
    drive(MMIO + 8, 32'h4, 0, 1, 3'd0, 0);
    idle(0);
    chk("ovf_clr", 32'(memError), 32'h0);

    // counter difference
    drive(MMIO + 4, 0, 1, 0, 3'd0, 0);
    c1 = readMemData;
    repeat (7) idle(0);
    drive(MMIO + 4, 0, 1, 0, 3'd0, 0);
    c2 = readMemData;
    chk("cnt_diff", c2 - c1, 32'd8);

    // reset mid-drain
    for (int i = 0; i < 3; i++) drive(MMIO, 32'h30 + 32'(i), 0, 1, 3'd0, 0);
    idle(1);
    chk("pre_rst_valid", 32'(txValid), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(txValid), 32'h0);
    chk("rst_mid_data", 32'(txData), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(MMIO, 0, 1, 0, 3'd0, 0);
    chk("post_rst_empty", readMemData, 32'h1);

    // randomized traffic
    repeat (3000) begin
      m = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 255));
        6: a = 32'hFFC + 32'($urandom_range(0, 3));
        7: begin
          a = MMIO + 32'($urandom_range(0, 63));
          if ($urandom_range(0, 3) != 0) begin a[1:0] = 2'b00; m = 3'd0; end
        end
        8: begin
          a = MMIO + 32'($urandom_range(0, 3) * 4);
          if ($urandom_range(0, 4) != 0) m = 3'd0;
        end
        default: begin
          case ($urandom_range(0, 2))
            0: a = 32'h1000 + 32'($urandom_range(0, 255));
            1: a = MMIO + 32'h40 + 32'($urandom_range(0, 63));
            default: a = MMIO - 32'd4;
          endcase
        end
      endcase
      drive(a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), m,
            1'($urandom_range(0, 1)));
    end
    idle(0);
    idle(0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
